// File: rtl/retire_trace_fifo_if.sv
// Record stream between the core retirement port, the trace FIFO and the trace consumers.
// TRACE_TIMESTAMP_EN adds a per-record cycle timestamp field (ts).
interface retire_trace_fifo_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic            rf_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_data;
    logic [3:0]      dm_be;
`ifdef TRACE_TIMESTAMP_EN
    logic [XLEN-1:0] ts;
`endif

    modport master (
`ifdef TRACE_TIMESTAMP_EN
        output ts,
`endif
        output valid, pc, rf_we, rd, rd_data, dm_we, dm_addr, dm_data, dm_be,
        input  ready
    );

    modport slave (
`ifdef TRACE_TIMESTAMP_EN
        input  ts,
`endif
        input  valid, pc, rf_we, rd, rd_data, dm_we, dm_addr, dm_data, dm_be,
        output ready
    );
endinterface

// File: rtl/retire_trace_fifo.sv
// In-order buffer of retirement records with overflow accounting (sticky flag + saturating drop count).
// Optional feature macro: TRACE_TIMESTAMP_EN (per-record push-cycle timestamp on trc.ts).
module retire_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    retire_trace_fifo_if.slave     ret,
    retire_trace_fifo_if.master    trc,
    output logic [$clog2(DEPTH):0] trc_count,
    output logic                   ovf_sticky,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [XLEN-1:0] ts;
`endif
        logic [XLEN-1:0] pc;
        logic            rf_we;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            dm_we;
        logic [XLEN-1:0] dm_addr;
        logic [XLEN-1:0] dm_data;
        logic [3:0]      dm_be;
    } rec_t;

    rec_t mem [DEPTH];
    rec_t wr_rec;
    rec_t head_rec;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg,  count_next;
    logic          sticky_reg;
    logic [CNT_W-1:0] drop_cnt_reg;

    logic full, empty, push, pop, drop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = !empty && trc.ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push  = ret.valid && (!full || pop);
    assign drop  = ret.valid && full && !pop;
    assign ret.ready = !full || pop;

`ifdef TRACE_TIMESTAMP_EN
    logic [XLEN-1:0] ts_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    assign wr_rec.ts = ts_reg;
`endif

    assign wr_rec.pc      = ret.pc;
    assign wr_rec.rf_we   = ret.rf_we;
    assign wr_rec.rd      = ret.rd;
    assign wr_rec.rd_data = ret.rd_data;
    assign wr_rec.dm_we   = ret.dm_we;
    assign wr_rec.dm_addr = ret.dm_addr;
    assign wr_rec.dm_data = ret.dm_data;
    assign wr_rec.dm_be   = ret.dm_be;

    // Storage is deliberately left out of reset; emptiness gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_rec;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // A drop coinciding with a clear restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg   <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            sticky_reg <= 1'b1;
            if (ovf_clr) begin
                drop_cnt_reg <= CNT_W'(1);
            end else if (drop_cnt_reg != CNT_MAX) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end else if (ovf_clr) begin
            sticky_reg   <= 1'b0;
            drop_cnt_reg <= '0;
        end
    end

    assign head_rec = empty ? '0 : mem[rd_ptr_reg];

    assign trc.valid   = !empty;
    assign trc.pc      = head_rec.pc;
    assign trc.rf_we   = head_rec.rf_we;
    assign trc.rd      = head_rec.rd;
    assign trc.rd_data = head_rec.rd_data;
    assign trc.dm_we   = head_rec.dm_we;
    assign trc.dm_addr = head_rec.dm_addr;
    assign trc.dm_data = head_rec.dm_data;
    assign trc.dm_be   = head_rec.dm_be;
`ifdef TRACE_TIMESTAMP_EN
    assign trc.ts      = head_rec.ts;
`endif

    assign trc_count  = count_reg;
    assign ovf_sticky = sticky_reg;
    assign drop_cnt   = drop_cnt_reg;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Randomised and directed bench for retire_trace_fifo against a queue-based record model.
// Build with TRACE_TIMESTAMP_EN defined to also cover the timestamp field.
module tb_retire_trace_fifo;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  trc_count;
    logic        ovf_sticky;
    logic [15:0] drop_cnt;
    logic        ovf_clr = 1'b0;

    retire_trace_fifo_if #(.XLEN(XLEN)) ret_if ();
    retire_trace_fifo_if #(.XLEN(XLEN)) trc_if ();

    retire_trace_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ret        (ret_if.slave),
        .trc        (trc_if.master),
        .trc_count  (trc_count),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_data;
        logic [3:0]  dm_be;
        logic [31:0] ts;
    } rec_t;

    rec_t        mq[$];
    int          m_drops;
    bit          m_sticky;
    logic [31:0] m_ts;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic rec_t mk(input logic [31:0] pc);
        rec_t r;
        r.pc      = pc;
        r.rf_we   = 1'($urandom);
        r.rd      = 5'($urandom);
        r.rd_data = $urandom;
        r.dm_we   = 1'($urandom);
        r.dm_addr = $urandom;
        r.dm_data = $urandom;
        r.dm_be   = 4'($urandom);
        r.ts      = '0;
        return r;
    endfunction

    // Reference: records leave in arrival order; a record offered to a full FIFO with no departure is lost.
    task automatic model_edge(input bit v, input rec_t r, input bit rdy, input bit clr);
        bit   pop, full, drop;
        rec_t rr;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        drop = v && full && !pop;
        rr    = r;
        rr.ts = m_ts;
        if (pop) void'(mq.pop_front());
        if (v && !drop) mq.push_back(rr);
        if (drop) begin
            m_sticky = 1'b1;
            m_drops  = clr ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
        end else if (clr) begin
            m_sticky = 1'b0;
            m_drops  = 0;
        end
        m_ts = m_ts + 1;
    endtask

    task automatic step(input bit v, input rec_t r, input bit rdy, input bit clr);
        ret_if.valid   = v;
        ret_if.pc      = r.pc;
        ret_if.rf_we   = r.rf_we;
        ret_if.rd      = r.rd;
        ret_if.rd_data = r.rd_data;
        ret_if.dm_we   = r.dm_we;
        ret_if.dm_addr = r.dm_addr;
        ret_if.dm_data = r.dm_data;
        ret_if.dm_be   = r.dm_be;
        trc_if.ready   = rdy;
        ovf_clr        = clr;
        @(posedge clk);
        model_edge(v, r, rdy, clr);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ret_if.valid = 1'b0;
        trc_if.ready = 1'b0;
        ovf_clr = 1'b0;
        mq.delete();
        m_drops  = 0;
        m_sticky = 1'b0;
        m_ts     = '0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            rec_t h;
            bit   ne;
            ne = (mq.size() != 0);
            if (ne) h = mq[0];
            else h = '{default: '0};
            check("valid", trc_if.valid, ne);
            check("pc", trc_if.pc, h.pc);
            check("rf", {trc_if.rf_we, trc_if.rd, trc_if.rd_data}, {h.rf_we, h.rd, h.rd_data});
            check("dm_addr", {trc_if.dm_we, trc_if.dm_be, trc_if.dm_addr}, {h.dm_we, h.dm_be, h.dm_addr});
            check("dm_data", trc_if.dm_data, h.dm_data);
`ifdef TRACE_TIMESTAMP_EN
            check("ts", trc_if.ts, h.ts);
`endif
            check("count", trc_count, mq.size());
            check("sticky", ovf_sticky, m_sticky);
            check("drop_cnt", drop_cnt, m_drops);
        end
    end

    initial begin
        rec_t idle, r10;
        idle = '{default: '0};
        #1;
        do_reset();
        chk_en = 1'b1;
        check("rst_valid", trc_if.valid, 0);
        check("rst_count", trc_count, 0);
        check("rst_pc", trc_if.pc, 0);
        check("rst_drop", {ovf_sticky, drop_cnt}, 0);

        // Single record, held three cycles, then popped.
        r10 = idle;
        r10.pc = 32'h10; r10.rf_we = 1'b1; r10.rd = 5'd5; r10.rd_data = 32'hDEADBEEF;
        step(1, r10, 0, 0);
        check("t1_valid", trc_if.valid, 1);
        check("t1_pc", trc_if.pc, 32'h10);
        check("t1_count", trc_count, 1);
        repeat (3) step(0, idle, 0, 0);
        check("t1_hold_pc", trc_if.pc, 32'h10);
        check("t1_hold_rd", {trc_if.rd, trc_if.rd_data}, {5'd5, 32'hDEADBEEF});
        step(0, idle, 1, 0);
        check("t1_empty_count", trc_count, 0);
        check("t1_empty_data", {trc_if.valid, trc_if.pc, trc_if.rd_data}, 0);

        // Overfill by two.
        for (int i = 0; i < 10; i++) step(1, mk(32'h100 + 4 * i), 0, 0);
        check("t2_count", trc_count, 8);
        check("t2_sticky", ovf_sticky, 1);
        check("t2_drop", drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check("t2_drain_pc", trc_if.pc, 32'h100 + 4 * i);
            step(0, idle, 1, 0);
        end
        check("t2_drained", trc_count, 0);
        step(0, idle, 0, 1);
        check("t2_clr", {ovf_sticky, drop_cnt}, 0);

        // Full with simultaneous push and pop; pointers wrap on this fill.
        for (int i = 0; i < 8; i++) step(1, mk(32'h200 + 4 * i), 0, 0);
        step(1, mk(32'h300), 1, 0);
        check("t3_count", trc_count, 8);
        check("t3_drop", drop_cnt, 0);
        for (int i = 1; i < 9; i++) begin
            check("t3_drain_pc", trc_if.pc, (i == 8) ? 32'h300 : 32'h200 + 4 * i);
            step(0, idle, 1, 0);
        end

        // Streaming through an empty FIFO.
        for (int i = 0; i < 20; i++) begin
            step(1, mk(32'h400 + 4 * i), 1, 0);
            check("t4_pc", trc_if.pc, 32'h400 + 4 * i);
            check("t4_count", trc_count, 1);
        end
        step(0, idle, 1, 0);
        check("t4_nodrop", drop_cnt, 0);

        // Clear coinciding with a drop, then clear alone, then asynchronous reset with 5 queued.
        for (int i = 0; i < 8; i++) step(1, mk(32'h600 + 4 * i), 0, 0);
        step(1, mk(32'h700), 0, 1);
        check("t5_clr_drop", {ovf_sticky, drop_cnt}, {1'b1, 16'd1});
        step(0, idle, 0, 1);
        check("t5_clr_only", {ovf_sticky, drop_cnt}, 0);
        repeat (3) step(0, idle, 1, 0);
        check("t5_five", trc_count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", trc_if.valid, 0);
        check("t5_async_count", trc_count, 0);
        do_reset();
        step(1, mk(32'h500), 0, 0);
        check("t5_post_pc", trc_if.pc, 32'h500);
        step(0, idle, 1, 0);

        // Timestamps: pushes on the edges where the cycle counter reads 3 and 7.
        do_reset();
        repeat (3) step(0, idle, 0, 0);
        step(1, mk(32'h800), 0, 0);
        repeat (3) step(0, idle, 0, 0);
        step(1, mk(32'h804), 0, 0);
`ifdef TRACE_TIMESTAMP_EN
        check("t6_ts3", trc_if.ts, 3);
`endif
        check("t6_pc0", trc_if.pc, 32'h800);
        step(0, idle, 1, 0);
`ifdef TRACE_TIMESTAMP_EN
        check("t6_ts7", trc_if.ts, 7);
`endif
        check("t6_pc1", trc_if.pc, 32'h804);
        step(0, idle, 1, 0);

        // Random traffic alternating between drain-heavy and fill-heavy phases.
        for (int i = 0; i < 800; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 100) % 2 == 1) ? 85 : 25;
            step($urandom_range(0, 99) < 70, mk($urandom),
                 $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Buffers per-instruction retirement records from the rv32i core (PC, register-file writeback, data-memory store) and presents them in order to the trace consumers (instruction, data and register-file monitors/checkers) over a valid/ready stream.
- Sits directly downstream of the core's writeback stage. Absorbs back-pressure from the consumer side and accounts for any record lost to overflow.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- XLEN, 32, data and address width.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  XLEN  PC of retiring instruction.
- ret_rf_we  in  1  instruction writes the register file.
- ret_rd  in  5  destination register.
- ret_rd_data  in  XLEN  writeback value.
- ret_dm_we  in  1  instruction stores to data memory.
- ret_dm_addr  in  XLEN  store address.
- ret_dm_data  in  XLEN  store data.
- ret_dm_be  in  4  store byte enables.
- trc_valid  out  1  head record valid.
- trc_ready  in  1  consumer accepts head.
- trc_pc, trc_rf_we, trc_rd, trc_rd_data, trc_dm_we, trc_dm_addr, trc_dm_data, trc_dm_be  out  as input  head record fields.
- trc_count  out  $clog2(DEPTH)+1  current occupancy.
- ovf_sticky  out  1  at least one record dropped since last clear.
- drop_cnt  out  CNT_W  dropped-record count, saturating.
- ovf_clr  in  1  synchronous clear of ovf_sticky and drop_cnt.

Behaviour:
- Storage:
  - Circular buffer with write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 to 0.
  - Occupancy counter runs 0..DEPTH. full = (count == DEPTH); empty = (count == 0).
- Reset (async, rst_n low): pointers 0, count 0, trc_valid 0, all trc_* data outputs 0, ovf_sticky 0, drop_cnt 0.
- Storage array contents are not reset. Outputs must read 0 while empty, independent of array contents.
- Push: ret_valid && (!full || pop) writes one entry at the write pointer and advances it.
- Pop: trc_valid && trc_ready advances the read pointer.
- Latency: a record pushed at edge N is visible on trc_* with trc_valid=1 after edge N when the FIFO was empty (one-cycle latency). Otherwise it appears in order behind older entries.
- Head outputs are driven from the entry at the read pointer, gated to 0 while empty.
- Handshake: once trc_valid rises, trc_valid and the head fields stay stable until the pop handshake completes.
- Simultaneous push and pop:
  - count unchanged.
  - When full, the push is accepted because a slot frees in the same cycle.
  - When empty, no pop occurs (trc_valid=0); the push is accepted.
- Overflow: ret_valid && full && !pop drops the record.
  - Set ovf_sticky.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - FIFO contents unchanged.
- ovf_clr: clears ovf_sticky and drop_cnt next edge. A drop in the same cycle as ovf_clr wins: ovf_sticky=1, drop_cnt=1.
- ret_valid=0: no push, regardless of the other ret_* inputs. Field values with rf_we=0 or dm_we=0 are stored unchanged (not masked).
- Reset mid-operation: all queued records are discarded; the first post-reset push lands at index 0.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running cycle counter, XLEN bits, reset 0, wrapping at 2^XLEN.
  - Each pushed entry captures the counter value of its push cycle.
  - Adds output trc_ts (XLEN), part of the head record and subject to the same stability and zero-when-empty rules.
- Undefined: no counter, no trc_ts port, no timestamp storage.

Test Plan:
- Reset, then a single push of pc=0x00000010, rd=5, rd_data=0xDEADBEEF with trc_ready=0 -> next cycle trc_valid=1, trc_pc=0x10, trc_count=1. Fields hold steady for 3 cycles; after a pop with trc_ready=1, count=0 and outputs read 0.
- DEPTH=8, push 10 consecutive records with trc_ready=0 -> count=8, ovf_sticky=1, drop_cnt=2. Draining yields the first 8 PCs in order; pointers wrap on the next fill.
- Full FIFO with push and pop in the same cycle -> count stays 8, drop_cnt unchanged, new record appears last on drain.
- Empty FIFO with ret_valid=1 and trc_ready=1 held for 20 cycles -> no drops; each record is emitted exactly once with one-cycle latency.
- ovf_clr asserted in the same cycle as a drop -> ovf_sticky=1, drop_cnt=1. A following ovf_clr alone -> both 0. Assert rst_n low with 5 entries queued -> trc_valid=0 and count=0 immediately (asynchronous).
- With TRACE_TIMESTAMP_EN: push at cycles 3 and 7 after reset release -> trc_ts reads 3, then 7 on drain.
